// File: rtl/trdb_pkg.sv
// Shared types for the trace debugger branch-map path: map capacity,
// output-slot state encoding and the packet layout handed downstream.
package trdb_pkg;

  localparam int unsigned BMAP_LEN_DEFAULT = 31;
  localparam int unsigned CNT_W            = 5;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  typedef struct packed {
    logic [BMAP_LEN_DEFAULT-1:0] bmap;
    logic [CNT_W-1:0]            branches;
    logic                        updiscon;
  } bmap_pkt_t;

endpackage

// File: rtl/trdb_branch_map_ctrl.sv
// Accumulates conditional-branch outcomes into a branch map and hands closed
// maps to a single registered output slot with a valid/ready handshake.
module trdb_branch_map_ctrl
  import trdb_pkg::*;
#(
  parameter int unsigned BMAP_LEN = BMAP_LEN_DEFAULT
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                valid_i,
  input  logic                is_branch_i,
  input  logic                is_branch_taken_i,
  input  logic                updiscon_i,
  input  logic                flush_i,
  output logic                ready_o,
  output logic                pkt_valid_o,
  input  logic                pkt_ready_i,
  output logic [BMAP_LEN-1:0] pkt_bmap_o,
  output logic [CNT_W-1:0]    pkt_branches_o,
  output logic                pkt_updiscon_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BMAP_LEN);

  slot_state_e         state;
  bmap_pkt_t           slot;
  logic [BMAP_LEN-1:0] acc_map;
  logic [BMAP_LEN-1:0] map_nxt;
  logic [CNT_W-1:0]    acc_cnt;
  logic [CNT_W-1:0]    cnt_nxt;
  logic                br_in;
  logic                close_req;
  logic                stall;
  logic                accept;
  logic                close;

  // The close decision looks at the map as it would be after this cycle's
  // branch, so a same-cycle branch always lands in the packet it closes.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    br_in   = valid_i && is_branch_i;
    map_nxt = acc_map;
    if (br_in) begin
      map_nxt[acc_cnt] = ~is_branch_taken_i;
    end
    cnt_nxt   = acc_cnt + CNT_W'(br_in);
    close_req = (br_in && (cnt_nxt == CNT_MAX))
             || (valid_i && updiscon_i)
             || (flush_i && (cnt_nxt != '0));
    // A close can only proceed if the slot is free or being drained this cycle.
    stall  = !rst_i && (state == SLOT_FULL) && !pkt_ready_i && close_req;
    accept = valid_i && !stall;
    close  = close_req && !stall;
  end

  assign ready_o = !stall;

  always_ff @(posedge clk_i) begin
    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst_i) begin
      state   <= SLOT_EMPTY;
      acc_map <= '0;
      acc_cnt <= '0;
      slot    <= '0;
    end else if (close) begin
      state         <= SLOT_FULL;
      slot.bmap     <= BMAP_LEN_DEFAULT'(map_nxt);
      slot.branches <= cnt_nxt;
      slot.updiscon <= valid_i && updiscon_i;
      acc_map       <= '0;
      acc_cnt       <= '0;
    end else begin
      if (accept && is_branch_i) begin
        acc_map <= map_nxt;
        acc_cnt <= cnt_nxt;
      end
      if ((state == SLOT_FULL) && pkt_ready_i) begin
        state <= SLOT_EMPTY;
        slot  <= '0;
      end
    end
  end

  assign pkt_valid_o    = (state == SLOT_FULL);
  assign pkt_bmap_o     = slot.bmap[BMAP_LEN-1:0];
  assign pkt_branches_o = slot.branches;
  assign pkt_updiscon_o = slot.updiscon;

endmodule

// File: tb/tb_trdb_branch_map_ctrl.sv
// Scoreboard bench for trdb_branch_map_ctrl: a cycle model predicts ready_o
// and closed packets; a negedge monitor compares packets on each handshake.
module tb_trdb_branch_map_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic        is_branch_i;
  logic        is_branch_taken_i;
  logic        updiscon_i;
  logic        flush_i;
  logic        ready_o;
  logic        pkt_valid_o;
  logic        pkt_ready_i;
  logic [30:0] pkt_bmap_o;
  logic [4:0]  pkt_branches_o;
  logic        pkt_updiscon_o;

  trdb_branch_map_ctrl #(.BMAP_LEN(31)) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .valid_i           (valid_i),
    .is_branch_i       (is_branch_i),
    .is_branch_taken_i (is_branch_taken_i),
    .updiscon_i        (updiscon_i),
    .flush_i           (flush_i),
    .ready_o           (ready_o),
    .pkt_valid_o       (pkt_valid_o),
    .pkt_ready_i       (pkt_ready_i),
    .pkt_bmap_o        (pkt_bmap_o),
    .pkt_branches_o    (pkt_branches_o),
    .pkt_updiscon_o    (pkt_updiscon_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [30:0] bmap;
    logic [4:0]  branches;
    logic        updiscon;
  } exp_pkt_t;

  exp_pkt_t    sb[$];
  int          total = 0;
  int          bad   = 0;

  logic [30:0] m_map;
  int          m_cnt;
  logic        m_full;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk_i) begin
    if (!rst_i && pkt_valid_o && pkt_ready_i) begin
      if (sb.size() == 0) begin
        check("pkt_unexpected", pkt_valid_o, 1'b0);
      end else begin
        exp_pkt_t e;
        e = sb.pop_front();
        check("pkt_bmap", pkt_bmap_o, e.bmap);
        check("pkt_branches", pkt_branches_o, e.branches);
        check("pkt_updiscon", pkt_updiscon_o, e.updiscon);
      end
    end
  end

  // Drive one cycle of stimulus, predict ready_o and the close, then advance.
  task automatic step(input logic v, input logic b, input logic t, input logic u,
                      input logic f, output logic acc);
    logic [30:0] mm;
    int          cn;
    logic        br, creq, er;
    valid_i = v; is_branch_i = b; is_branch_taken_i = t; updiscon_i = u; flush_i = f;
    @(negedge clk_i);
    br = v && b;
    mm = m_map;
    if (br) mm[m_cnt] = !t;
    cn   = m_cnt + (br ? 1 : 0);
    creq = (br && cn == 31) || (v && u) || (f && cn != 0);
    er   = !(m_full && !pkt_ready_i && creq);
    check("ready_o", ready_o, er);
    acc = er && v;
    if (er) begin
      if (creq) begin
        sb.push_back('{bmap: mm, branches: 5'(cn), updiscon: v && u});
        m_map  = '0;
        m_cnt  = 0;
        m_full = 1'b1;
      end else begin
        m_map = mm;
        m_cnt = cn;
        if (m_full && pkt_ready_i) m_full = 1'b0;
      end
    end
    @(posedge clk_i);
    #1;
    valid_i = 0; is_branch_i = 0; is_branch_taken_i = 0; updiscon_i = 0; flush_i = 0;
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, a);
  endtask

  initial begin
    logic a;
    rst_i = 1; valid_i = 0; is_branch_i = 0; is_branch_taken_i = 0;
    updiscon_i = 0; flush_i = 0; pkt_ready_i = 1;
    m_map = '0; m_cnt = 0; m_full = 0;
    @(negedge clk_i);
    check("rst_ready", ready_o, 1'b1);
    check("rst_pkt_valid", pkt_valid_o, 1'b0);
    @(posedge clk_i); #1;
    check("rst_bmap", pkt_bmap_o, 31'd0);
    check("rst_branches", pkt_branches_o, 5'd0);
    rst_i = 0;

    // Taken, not taken, taken, then flush.
    step(1, 1, 1, 0, 0, a);
    step(1, 1, 0, 0, 0, a);
    step(1, 1, 1, 0, 0, a);
    step(0, 0, 0, 0, 1, a);
    check("t1_valid", pkt_valid_o, 1'b1);
    check("t1_branches", pkt_branches_o, 5'd3);
    check("t1_bmap", pkt_bmap_o, 31'b010);
    check("t1_updiscon", pkt_updiscon_o, 1'b0);
    idle(1);

    // A full map of not-taken branches closes itself.
    for (int i = 0; i < 31; i++) step(1, 1, 0, 0, 0, a);
    check("t2_valid", pkt_valid_o, 1'b1);
    check("t2_branches", pkt_branches_o, 5'd31);
    check("t2_bmap", pkt_bmap_o, {31{1'b1}});
    step(0, 0, 0, 0, 1, a);
    check("t2_cnt_cleared", pkt_valid_o, 1'b0);

    // Updiscon on an empty map still yields a packet.
    step(1, 0, 0, 1, 0, a);
    check("t3_valid", pkt_valid_o, 1'b1);
    check("t3_branches", pkt_branches_o, 5'd0);
    check("t3_updiscon", pkt_updiscon_o, 1'b1);
    idle(1);

    // Random mix with random downstream back-pressure.
    for (int i = 0; i < 300; i++) begin
      pkt_ready_i = ($urandom_range(0, 9) < 7);
      step($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 6, $urandom_range(0, 1),
           $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0, a);
    end
    pkt_ready_i = 1;
    idle(3);
    check("t4_drained", pkt_valid_o, 1'b0);
    step(0, 0, 0, 0, 1, a);
    idle(2);

    // Slot held full while a second map fills; 31st branch must stall.
    step(1, 1, 0, 0, 0, a);
    step(1, 1, 1, 0, 0, a);
    pkt_ready_i = 0;
    step(0, 0, 0, 0, 1, a);
    for (int i = 0; i < 30; i++) begin
      step(1, 1, $urandom_range(0, 1), 0, 0, a);
      check("t5_accept", a, 1'b1);
    end
    step(1, 1, 1, 0, 0, a);
    check("t5_stall0", a, 1'b0);
    step(1, 1, 1, 0, 0, a);
    check("t5_stall1", a, 1'b0);
    check("t5_hold_branches", pkt_branches_o, 5'd2);
    pkt_ready_i = 1;
    step(1, 1, 1, 0, 0, a);
    check("t5_accept31", a, 1'b1);
    check("t5_second_valid", pkt_valid_o, 1'b1);
    check("t5_second_branches", pkt_branches_o, 5'd31);
    idle(2);

    // Drain and refill in the same cycle.
    pkt_ready_i = 0;
    step(1, 1, 1, 0, 1, a);
    pkt_ready_i = 1;
    step(1, 1, 1, 1, 0, a);
    check("t6_valid", pkt_valid_o, 1'b1);
    check("t6_updiscon", pkt_updiscon_o, 1'b1);
    check("t6_branches", pkt_branches_o, 5'd1);
    check("t6_bmap", pkt_bmap_o, 31'd0);
    idle(2);

    // Reset with a full slot and a partial map discards everything.
    pkt_ready_i = 0;
    step(1, 0, 0, 1, 0, a);
    for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 0, a);
    rst_i = 1; flush_i = 1;
    @(negedge clk_i);
    check("t7_ready_in_rst", ready_o, 1'b1);
    @(posedge clk_i); #1;
    check("t7_valid", pkt_valid_o, 1'b0);
    check("t7_bmap", pkt_bmap_o, 31'd0);
    check("t7_branches", pkt_branches_o, 5'd0);
    check("t7_updiscon", pkt_updiscon_o, 1'b0);
    check("t7_ready", ready_o, 1'b1);
    rst_i = 0; flush_i = 0;
    sb.delete();
    m_map = '0; m_cnt = 0; m_full = 0;
    step(0, 0, 0, 0, 1, a);
    check("t7_no_pkt", pkt_valid_o, 1'b0);
    pkt_ready_i = 1;
    idle(2);

    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/trdb_branch_map_ctrl.md
TRDB_BRANCH_MAP_CTRL -- requirements
Module: trdb_branch_map_ctrl

Interface
REQ-001 SHALL have parameter BMAP_LEN, default 31: branch-map capacity in bits.
REQ-002 SHALL have port clk_i, input, 1: clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port valid_i, input, 1: one retired instruction is presented this cycle.
REQ-005 SHALL have port is_branch_i, input, 1: the presented instruction is a conditional branch.
REQ-006 SHALL have port is_branch_taken_i, input, 1: the branch was taken; meaningful only when is_branch_i is high.
REQ-007 SHALL have port updiscon_i, input, 1: the presented instruction is an uninferable discontinuity.
REQ-008 SHALL have port flush_i, input, 1: external request to emit the pending map (exception, context change, trace stop).
REQ-009 SHALL have port ready_o, output, 1: instruction accepted this cycle when valid_i && ready_o.
REQ-010 SHALL have port pkt_valid_o, output, 1: a map packet is offered downstream.
REQ-011 SHALL have port pkt_ready_i, input, 1: downstream accepts the packet.
REQ-012 SHALL have port pkt_bmap_o, output, BMAP_LEN: branch map; bit i holds branch i in program order.
REQ-013 SHALL have port pkt_branches_o, output, 5: number of valid bits in pkt_bmap_o (0..BMAP_LEN).
REQ-014 SHALL have port pkt_updiscon_o, output, 1: the packet was closed by an updiscon.

Function
REQ-015 SHALL hold an accumulation map (acc_map) and a 5-bit count (acc_cnt), plus an output slot with FSM states SLOT_EMPTY and SLOT_FULL.
REQ-016 On an accepted branch, SHALL write bit acc_map[acc_cnt] = !is_branch_taken_i (1 = not taken) and increment acc_cnt.
REQ-017 SHALL raise a close event on an accepted instruction when any of these holds: the branch makes acc_cnt reach BMAP_LEN; updiscon_i is high; or flush_i is high with acc_cnt > 0 (flush_i is sampled whether or not valid_i is high).
REQ-018 On a close event, the post-update map and count, including a branch presented in the same cycle, SHALL be copied to the output slot in the next cycle; acc_map and acc_cnt then clear to 0.
REQ-019 A close due to updiscon with acc_cnt = 0 and no branch SHALL still emit a packet with pkt_branches_o = 0 and pkt_updiscon_o = 1.
REQ-020 SLOT_EMPTY -> SLOT_FULL on a close; SLOT_FULL -> SLOT_EMPTY when pkt_valid_o && pkt_ready_i with no simultaneous close; on an accept with a simultaneous close, SHALL stay SLOT_FULL and load the new packet (back-to-back, no bubble).
REQ-021 pkt_valid_o SHALL equal (state == SLOT_FULL); pkt_* outputs SHALL be registered and stable while pkt_valid_o && !pkt_ready_i.
REQ-022 ready_o SHALL be low only when the slot is SLOT_FULL, pkt_ready_i is low, and the presented instruction would cause a close; it is otherwise high. ready_o is combinational.
REQ-023 When ready_o is low, the instruction SHALL have no effect on state.
REQ-024 Packet latency SHALL be 1 cycle from the closing instruction to pkt_valid_o.
REQ-025 acc_cnt SHALL never exceed BMAP_LEN, and unused pkt_bmap_o bits at or above pkt_branches_o SHALL be 0.

Reset
REQ-026 With rst_i high at a clock edge, SHALL set state SLOT_EMPTY, acc_map = 0, acc_cnt = 0, pkt_valid_o = 0, pkt_bmap_o = 0, pkt_branches_o = 0, and pkt_updiscon_o = 0; an unaccepted packet is discarded.
REQ-027 ready_o SHALL be high during and after reset.

Structure
REQ-028 BMAP_LEN default, the slot-state enum, and a packed struct {bmap, branches, updiscon} SHALL live in trdb_pkg.
REQ-029 The block SHALL be a single module with no sub-modules; the branch/updiscon flags arrive from the existing instruction-type detector.

Verification
REQ-030 Three accepted branches (taken, not taken, taken), then flush_i -> one cycle later: pkt_valid_o = 1, pkt_branches_o = 3, pkt_bmap_o = 0b010, pkt_updiscon_o = 0.
REQ-031 31 consecutive not-taken branches with pkt_ready_i = 1 -> a packet with pkt_branches_o = 31 and pkt_bmap_o all-ones; acc_cnt = 0 afterwards.
REQ-032 updiscon with acc_cnt = 0 -> a packet with pkt_branches_o = 0, pkt_updiscon_o = 1.
REQ-033 Slot full and pkt_ready_i = 0, then 31 more branches -> ready_o drops on the 31st branch; after pkt_ready_i pulses, the 31st branch is accepted and the second packet emits without loss.
REQ-034 Packet accepted in the same cycle as a new updiscon close -> pkt_valid_o stays 1 and the next cycle shows the new contents.
REQ-035 rst_i asserted while SLOT_FULL and acc_cnt = 5 -> next cycle all outputs are 0 except ready_o = 1; a subsequent flush_i produces no packet.
